// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and a word-only data RAM.
// Extends loads, merges byte/halfword stores via read-modify-write, flags bad accesses.
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, MERGE_WR, RESP} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] old_q;
   logic [2:0]            funct3_q;

   logic                  accept;
   logic                  illegal;
   logic                  misaligned;
   logic                  err;
   logic                  is_sw;
   logic                  is_rmw;
   logic [4:0]            rd_shift;
   logic [DATA_WIDTH-1:0] rd_lane;
   logic [DATA_WIDTH-1:0] load_data;
   logic [4:0]            wr_shift;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic [DATA_WIDTH-1:0] merged;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign mem_a     = (state == IDLE) ? req_addr : addr_q;

   assign illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_store && req_funct3[2]);
   assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign err        = illegal || misaligned;
   assign is_sw      = req_store && (req_funct3 == 3'b010) && !err;
   assign is_rmw     = req_store && (req_funct3[2:1] == 2'b00) && !err;

   // Bring the addressed lane down to bit 0 before extension.
   assign rd_shift = {req_addr[1:0], 3'b000};
   assign rd_lane  = mem_rd >> rd_shift;

   // NOTE: every output of an always_comb gets a default first so no path infers a latch.
   always_comb begin
      load_data = '0;
      case (req_funct3)
         3'b000:  load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
         3'b001:  load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
         3'b010:  load_data = mem_rd;
         3'b100:  load_data = {24'd0, rd_lane[7:0]};
         3'b101:  load_data = {16'd0, rd_lane[15:0]};
         default: load_data = '0;
      endcase
   end

   assign wr_shift = {addr_q[1:0], 3'b000};
   assign wr_mask  = ((funct3_q == 3'b001) ? 32'h0000_FFFF : 32'h0000_00FF) << wr_shift;
   assign merged   = (old_q & ~wr_mask) | ((wdata_q << wr_shift) & wr_mask);

   always_comb begin
      state_n = state;
      mem_we  = 1'b0;
      mem_wd  = merged;
      case (state)
         IDLE: begin
            mem_wd = req_wdata;
            if (accept) begin
               mem_we  = is_sw;
               state_n = is_rmw ? MERGE_WR : RESP;
            end
         end
         MERGE_WR: begin
            mem_we  = 1'b1;
            state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Reset abandons any write in flight, including a pending merge.
      if (rst) mem_we = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         funct3_q   <= '0;
      end else begin
         state      <= state_n;
         resp_valid <= (state_n == RESP);
         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            old_q    <= mem_rd;
            funct3_q <= req_funct3;
            if (!is_rmw) begin
               resp_err   <= err;
               resp_rdata <= (req_store || err) ? '0 : load_data;
            end
         end
         if (state == MERGE_WR) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word RAM.
// Directed vectors push expected responses; a negedge monitor pops and compares.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] ram [0:63];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rd = ram[mem_a[7:2]];
   always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (resp_valid) begin
         check("resp_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
         check("we_in_resp", 32'(mem_we), 32'd0);
      end
   end

   task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input int lat, input logic [31:0] exp_mwd);
      exp_t e;
      bit   sw;
      sw = st && (f3 == 3'b010) && !exp_err;
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      check("req_ready", 32'(req_ready), 32'd1);
      check("accept_we", 32'(mem_we), 32'(sw));
      if (sw) check("sw_wd", mem_wd, wd);
      e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      if (lat == 2) begin
         check("merge_we", 32'(mem_we), 32'd1);
         check("merge_wd", mem_wd, exp_mwd);
      end else begin
         check("post_we", 32'(mem_we), 32'd0);
      end
      for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("resp_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'd0;
      ram[4]  = 32'h80FF7F01;
      ram[12] = 32'h11223344;
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'd0; req_wdata = 32'd0;

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_ready", 32'(req_ready), 32'd0);
         check("rst_we", 32'(mem_we), 32'd0);
         check("rst_resp_valid", 32'(resp_valid), 32'd0);
         check("rst_rdata", resp_rdata, 32'd0);
         check("rst_err", 32'(resp_err), 32'd0);
      end
      rst = 1'b0;

      // Loads from 0x80FF7F01 at 0x10.
      issue(0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0, 1, 0);
      issue(0, 3'b100, 32'h13, 0, 32'h00000080, 0, 1, 0);
      issue(0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 0, 1, 0);
      issue(0, 3'b101, 32'h12, 0, 32'h000080FF, 0, 1, 0);
      issue(0, 3'b010, 32'h10, 0, 32'h80FF7F01, 0, 1, 0);
      issue(0, 3'b000, 32'h10, 0, 32'h00000001, 0, 1, 0);
      issue(0, 3'b000, 32'h11, 0, 32'h0000007F, 0, 1, 0);

      // Word store then read back.
      issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 1, 0);
      issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 1, 0);

      // Sub-word read-modify-write.
      issue(1, 3'b000, 32'h21, 32'h12345678, 0, 0, 2, 32'hDEAD78EF);
      issue(1, 3'b001, 32'h22, 32'hAAAA5555, 0, 0, 2, 32'h555578EF);
      check("ram_20_rmw", ram[8], 32'h555578EF);

      // Errors: misaligned and illegal encodings.
      issue(0, 3'b010, 32'h22, 0, 0, 1, 1, 0);
      issue(1, 3'b001, 32'h23, 32'hFFFFFFFF, 0, 1, 1, 0);
      issue(0, 3'b011, 32'h10, 0, 0, 1, 1, 0);
      issue(1, 3'b100, 32'h20, 32'h0, 0, 1, 1, 0);
      issue(1, 3'b010, 32'h21, 32'h0, 0, 1, 1, 0);
      check("ram_20_after_err", ram[8], 32'h555578EF);
      check("ram_10_after_err", ram[4], 32'h80FF7F01);

      // Leave a non-zero result registered before the mid-merge reset.
      issue(0, 3'b010, 32'h20, 0, 32'h555578EF, 0, 1, 0);

      // Reset during MERGE_WR of SB 0x30: write abandoned, no response.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h30; req_wdata = 32'h000000AB;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("abort_rst_ready", 32'(req_ready), 32'd0);
         check("abort_rst_we", 32'(mem_we), 32'd0);
         check("abort_rst_resp_valid", 32'(resp_valid), 32'd0);
         check("abort_rst_rdata", resp_rdata, 32'd0);
      end
      rst = 1'b0;
      check("ram_30_kept", ram[12], 32'h11223344);
      issue(0, 3'b010, 32'h30, 0, 32'h11223344, 0, 1, 0);
      issue(0, 3'b001, 32'h32, 0, 32'h00001122, 0, 1, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU memory stage and the word-only data RAM. The RAM has a combinational read, a synchronous write and ignores address bits [1:0].
- Accepts one load or store request at a time on a valid/ready handshake, and performs sign or zero extension for loads.
- Implements byte and halfword stores as a two-cycle read-modify-write, and flags misaligned or illegal accesses instead of issuing them.
- Returns each result as a single-cycle response pulse.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width presented to the RAM.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; the result below is valid.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wd  out  DATA_WIDTH  RAM write data.
- mem_rd  in  DATA_WIDTH  RAM read data (combinational from mem_a).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, MERGE_WR, RESP.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, held address/data/funct3 registers=0.
- While rst=1: mem_we=0 and req_ready=0, regardless of state. A reset during MERGE_WR abandons the write, so the RAM word is unchanged.
- req_ready: 1 only in IDLE with rst=0. A request is accepted when req_valid && req_ready.
- mem_a: equals req_addr in IDLE and the held address in MERGE_WR/RESP. mem_a[1:0] is passed through and ignored by the RAM.
- Error check, made on acceptance:
  - illegal: funct3 in {011,110,111}, or a store with funct3[2]=1.
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
  - On error: no mem_we, go to RESP with resp_err=1 and resp_rdata=0.
- Load:
  - On the accept cycle, the lane at addr[1:0] of mem_rd is selected.
  - B/H are sign-extended; BU/HU are zero-extended; W passes the word through.
  - The result is registered; next state RESP. resp_valid rises 1 cycle after accept.
- Word store: mem_we=1 with mem_wd=req_wdata on the accept cycle (combinational from the request); next state RESP.
- Byte/halfword store (read-modify-write):
  - Accept cycle: capture mem_rd as the old word and hold addr, wdata and funct3; mem_we=0.
  - MERGE_WR (1 cycle): mem_we=1. mem_wd = old word with byte lane addr[1:0] (or halfword lane addr[1]) replaced by req_wdata[7:0] (or [15:0]); all other bytes are preserved.
  - Next state RESP. resp_valid rises 2 cycles after accept.
- RESP: resp_valid=1 for exactly one cycle; mem_we=0; next state IDLE. No response back-pressure.
- Throughput: one request per 2 cycles (loads, SW, errors); one per 3 cycles for SB/SH.
- Outside RESP: resp_valid=0. resp_rdata and resp_err hold their last values.
- mem_we is never asserted in RESP, or in IDLE without an accepted aligned SW.

Test Plan:
- Reset: hold rst 2 cycles mid-traffic -> req_ready=0, mem_we=0, resp_valid=0, resp_rdata=0 throughout; IDLE after release.
- Loads: RAM[0x10]=0x80FF7F01. LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF; LW 0x10 -> 0x80FF7F01. Each resp_valid is 1 cycle after accept.
- SW 0x20 with 0xDEADBEEF -> mem_we=1 only on the accept cycle; resp 1 cycle later with err=0; a subsequent LW 0x20 returns 0xDEADBEEF.
- Sub-word stores, RAM[0x20]=0xDEADBEEF:
  - SB 0x21 with 0x12345678 -> MERGE_WR writes 0xDEAD78EF; resp 2 cycles after accept.
  - Then SH 0x22 with 0xAAAA5555 -> 0x555578EF.
- Errors: LW 0x22, SH 0x23, and funct3=011 each -> resp_err=1, resp_rdata=0, mem_we never asserted, RAM unchanged.
- Reset during MERGE_WR of SB 0x30 (RAM[0x30]=0x11223344) -> no write occurs, RAM[0x30] stays 0x11223344, no resp_valid, next request accepted normally.
